// File: rtl/fft_iter_seq_unit.sv
// ---------------------------------------------------------------------------
// fft_iter_seq_unit
//
// Runtime-configurable sequencer for an iterative, in-place radix-2 DIT FFT.
// One butterfly is issued per enabled clock. For each layer s, butterfly k
// reads A = g*2^(s+1) + j and B = A + 2^s, where j = k mod 2^s and g = k >> s.
// The twiddle index is j << (AWL-1-s) into a 2^AWL-point table. After the
// last read of a layer the sequencer drains for RD_LAT+BUT_LAT cycles, so the
// last write of a layer completes before the first read of the next layer.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   EN              clock enable, freezes every register including delay lines
//   START           run request, only accepted in IDLE
//   i_LOG2N         FFT size log2 (valid 1..AWL), sampled with START
//   i_INVERSE       inverse-transform flag, sampled with START
//   o_BUSY          accepted START through the DONE cycle inclusive
//   o_DONE          one-cycle pulse after the last write of the last layer
//   o_ERR           one-cycle pulse after START with an invalid i_LOG2N
//   o_FIRST         high on layer-0 read cycles (input RAM select)
//   o_LAYER         current layer index
//   o_RD_EN         read issue strobe
//   o_RD_A_ADDR     butterfly A read address
//   o_RD_B_ADDR     butterfly B read address
//   o_W_ADDR        twiddle index, aligned with o_RD_EN
//   o_W_CONJ        latched i_INVERSE
//   o_BUT_STROB     o_RD_EN delayed RD_LAT
//   o_WR            o_RD_EN delayed RD_LAT+BUT_LAT
//   o_WR_A_ADDR     o_RD_A_ADDR delayed RD_LAT+BUT_LAT
//   o_WR_B_ADDR     o_RD_B_ADDR delayed RD_LAT+BUT_LAT
// ---------------------------------------------------------------------------
module fft_iter_seq_unit #(
  parameter int AWL     = 10,
  parameter int LayWL   = 4,
  parameter int RD_LAT  = 1,
  parameter int BUT_LAT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             START,
  input  logic [LayWL-1:0] i_LOG2N,
  input  logic             i_INVERSE,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_ERR,
  output logic             o_FIRST,
  output logic [LayWL-1:0] o_LAYER,
  output logic             o_RD_EN,
  output logic [AWL-1:0]   o_RD_A_ADDR,
  output logic [AWL-1:0]   o_RD_B_ADDR,
  output logic [AWL-2:0]   o_W_ADDR,
  output logic             o_W_CONJ,
  output logic             o_BUT_STROB,
  output logic             o_WR,
  output logic [AWL-1:0]   o_WR_A_ADDR,
  output logic [AWL-1:0]   o_WR_B_ADDR
);

  // Total read-to-write latency; also the drain length of every layer.
  localparam int D  = RD_LAT + BUT_LAT;
  // Delay-line word: {strobe, A address, B address}.
  localparam int DW = 2 * AWL + 1;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Address helpers
  // -------------------------------------------------------------------------

  // A address: insert a zero bit at position s of k, i.e. (k>>s)<<(s+1) | j.
  function automatic logic [AWL-1:0] addr_a_f(input logic [LayWL-1:0] s,
                                              input logic [AWL-2:0]   k);
    logic [AWL-1:0] kk;
    logic [AWL-1:0] mask;
    kk   = {1'b0, k};
    mask = (AWL'(1'b1) << s) - AWL'(1'b1);
    return ((kk & ~mask) << 1) | (kk & mask);
  endfunction

  // Twiddle index: j = k mod 2^s scaled to the full 2^AWL-point table.
  // For s = AWL-1 the shifted one wraps to zero, so the mask becomes all ones.
  function automatic logic [AWL-2:0] addr_w_f(input logic [LayWL-1:0] s,
                                              input logic [AWL-2:0]   k);
    logic [AWL-2:0] mask;
    mask = ((AWL-1)'(1'b1) << s) - (AWL-1)'(1'b1);
    return (k & mask) << (LayWL'(AWL - 1) - s);
  endfunction

  // Index of the last butterfly of a layer for an FFT of 2^l points.
  function automatic logic [AWL-2:0] last_k_f(input logic [LayWL-1:0] l);
    logic [AWL-1:0] t;
    t = (AWL'(1'b1) << (l - LayWL'(1'b1))) - AWL'(1'b1);
    return t[AWL-2:0];
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q;
  logic [LayWL-1:0] l_q;
  logic [LayWL-1:0] s_q;
  logic [AWL-2:0]   k_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             first_q;
  logic [LayWL-1:0] layer_q;
  logic             rd_en_q;
  logic [AWL-1:0]   rd_a_q;
  logic [AWL-1:0]   rd_b_q;
  logic [AWL-2:0]   w_q;
  logic             conj_q;
  logic [DW-1:0]    dly_q [D];

  // Next issued butterfly (layer, index) and its addresses.
  logic [LayWL-1:0] sel_s_d;
  logic [AWL-2:0]   sel_k_d;
  logic [AWL-1:0]   rd_a_d;
  logic [AWL-1:0]   rd_b_d;
  logic [AWL-2:0]   w_d;

  logic             log2n_ok_s;
  logic             last_k_s;
  logic             last_layer_s;
  logic             drain_end_s;

  assign log2n_ok_s   = (i_LOG2N != {LayWL{1'b0}}) && (i_LOG2N <= LayWL'(AWL));
  assign last_k_s     = (k_q == last_k_f(l_q));
  assign last_layer_s = (s_q == (l_q - LayWL'(1'b1)));
  assign drain_end_s  = (cnt_q == CW'(D - 1));

  // Select which butterfly will be issued at the next edge.
  always_comb begin
    sel_s_d = {LayWL{1'b0}};
    sel_k_d = {(AWL-1){1'b0}};
    case (state_q)
      ST_IDLE: begin
        sel_s_d = {LayWL{1'b0}};
        sel_k_d = {(AWL-1){1'b0}};
      end
      ST_READ: begin
        sel_s_d = s_q;
        sel_k_d = k_q + (AWL-1)'(1'b1);
      end
      ST_DRAIN: begin
        sel_s_d = s_q + LayWL'(1'b1);
        sel_k_d = {(AWL-1){1'b0}};
      end
      default: begin
        sel_s_d = {LayWL{1'b0}};
        sel_k_d = {(AWL-1){1'b0}};
      end
    endcase
  end

  // Address generation for the selected butterfly.
  always_comb begin
    rd_a_d = addr_a_f(sel_s_d, sel_k_d);
    rd_b_d = rd_a_d | (AWL'(1'b1) << sel_s_d);
    w_d    = addr_w_f(sel_s_d, sel_k_d);
  end

  // Control FSM with registered read-side outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      l_q     <= {LayWL{1'b0}};
      s_q     <= {LayWL{1'b0}};
      k_q     <= {(AWL-1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      layer_q <= {LayWL{1'b0}};
      rd_en_q <= 1'b0;
      rd_a_q  <= {AWL{1'b0}};
      rd_b_q  <= {AWL{1'b0}};
      w_q     <= {(AWL-1){1'b0}};
      conj_q  <= 1'b0;
    end else if (EN) begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            if (log2n_ok_s) begin
              state_q <= ST_READ;
              l_q     <= i_LOG2N;
              conj_q  <= i_INVERSE;
              s_q     <= {LayWL{1'b0}};
              k_q     <= {(AWL-1){1'b0}};
              layer_q <= {LayWL{1'b0}};
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
              first_q <= 1'b1;
              rd_a_q  <= rd_a_d;
              rd_b_q  <= rd_b_d;
              w_q     <= w_d;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (last_k_s) begin
            // Last butterfly of the layer has been issued: let the pipe empty.
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
          end else begin
            k_q    <= sel_k_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            w_q    <= w_d;
          end
        end
        ST_DRAIN: begin
          if (drain_end_s) begin
            // The last write of this layer is on the outputs now.
            if (last_layer_s) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_READ;
              s_q     <= sel_s_d;
              layer_q <= sel_s_d;
              k_q     <= {(AWL-1){1'b0}};
              rd_en_q <= 1'b1;
              rd_a_q  <= rd_a_d;
              rd_b_q  <= rd_b_d;
              w_q     <= w_d;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1'b1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
          first_q <= 1'b0;
        end
      endcase
    end
  end

  // Read-to-write delay line carrying the strobe and both addresses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < D; i++) begin
        dly_q[i] <= {DW{1'b0}};
      end
    end else if (EN) begin
      dly_q[0] <= {rd_en_q, rd_a_q, rd_b_q};
      for (int i = 1; i < D; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign o_BUSY      = busy_q;
  assign o_DONE      = done_q;
  assign o_ERR       = err_q;
  assign o_FIRST     = first_q;
  assign o_LAYER     = layer_q;
  assign o_RD_EN     = rd_en_q;
  assign o_RD_A_ADDR = rd_a_q;
  assign o_RD_B_ADDR = rd_b_q;
  assign o_W_ADDR    = w_q;
  assign o_W_CONJ    = conj_q;
  assign o_BUT_STROB = dly_q[RD_LAT-1][DW-1];
  assign o_WR        = dly_q[D-1][DW-1];
  assign o_WR_A_ADDR = dly_q[D-1][2*AWL-1:AWL];
  assign o_WR_B_ADDR = dly_q[D-1][AWL-1:0];

endmodule

// File: tb/tb_fft_iter_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_fft_iter_seq_unit
//
// Randomized self-checking bench for fft_iter_seq_unit (AWL=5, D=5). For each
// run, the expected butterfly schedule is enumerated directly from the FFT
// layer structure (groups and offsets, plain arithmetic) together with the
// enabled-cycle number at which every read, butterfly strobe and write must
// appear. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fft_iter_seq_unit;

  localparam int AWL     = 5;
  localparam int LAYWL   = 4;
  localparam int RD_LAT  = 1;
  localparam int BUT_LAT = 4;
  localparam int D       = RD_LAT + BUT_LAT;

  logic             CLK   = 1'b0;
  logic             RST   = 1'b0;
  logic             EN    = 1'b1;
  logic             START = 1'b0;
  logic [LAYWL-1:0] LOG2N = 4'd0;
  logic             INV   = 1'b0;

  logic             o_BUSY, o_DONE, o_ERR, o_FIRST, o_RD_EN, o_W_CONJ;
  logic             o_BUT_STROB, o_WR;
  logic [LAYWL-1:0] o_LAYER;
  logic [AWL-1:0]   o_RD_A_ADDR, o_RD_B_ADDR, o_WR_A_ADDR, o_WR_B_ADDR;
  logic [AWL-2:0]   o_W_ADDR;

  fft_iter_seq_unit #(
    .AWL(AWL), .LayWL(LAYWL), .RD_LAT(RD_LAT), .BUT_LAT(BUT_LAT)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START),
    .i_LOG2N(LOG2N), .i_INVERSE(INV),
    .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERR(o_ERR), .o_FIRST(o_FIRST),
    .o_LAYER(o_LAYER), .o_RD_EN(o_RD_EN),
    .o_RD_A_ADDR(o_RD_A_ADDR), .o_RD_B_ADDR(o_RD_B_ADDR),
    .o_W_ADDR(o_W_ADDR), .o_W_CONJ(o_W_CONJ), .o_BUT_STROB(o_BUT_STROB),
    .o_WR(o_WR), .o_WR_A_ADDR(o_WR_A_ADDR), .o_WR_B_ADDR(o_WR_B_ADDR)
  );

  always #5 CLK = ~CLK;

  // All outputs packed together for reset and freeze checks.
  logic [35:0] outs_w;
  assign outs_w = {o_BUSY, o_DONE, o_ERR, o_FIRST, o_LAYER, o_RD_EN,
                   o_RD_A_ADDR, o_RD_B_ADDR, o_W_ADDR, o_W_CONJ,
                   o_BUT_STROB, o_WR, o_WR_A_ADDR, o_WR_B_ADDR};

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int cyc;
    int a;
    int b;
    int w;
    int s;
  } rd_t;

  rd_t exp_q[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic err_test(input int l);
    @(negedge CLK);
    EN = 1'b1; START = 1'b1; LOG2N = 4'(l);
    @(negedge CLK);
    START = 1'b0;
    chk("err_pulse", o_ERR, 1);
    chk("err_busy", o_BUSY, 0);
    chk("err_rd", o_RD_EN, 0);
    @(negedge CLK);
    chk("err_clear", o_ERR, 0);
    chk("err_busy2", o_BUSY, 0);
  endtask

  task automatic run(input int l, input bit inv, input bit noise,
                     input bit en_rand, input int freeze_at, input int abort_at);
    int n, tot, done_cyc, ecyc, wall, ri, bi, wi, frz_left, half;
    bit fresh, en_used, got_done, exp_rd, exp_bs, exp_wr;
    logic [35:0] prev;
    rd_t e;

    // Reference schedule: layers, groups of 2*half points, offsets inside a group.
    n = 1 << l;
    exp_q.delete();
    for (int s = 0; s < l; s++) begin
      half = 1 << s;
      for (int g = 0; g < n / (2 * half); g++) begin
        for (int j = 0; j < half; j++) begin
          e.cyc = 1 + s * (n / 2 + D) + g * half + j;
          e.a   = g * 2 * half + j;
          e.b   = e.a + half;
          e.w   = j * ((1 << AWL) / (2 * half));
          e.s   = s;
          exp_q.push_back(e);
        end
      end
    end
    tot      = exp_q.size();
    done_cyc = l * (n / 2 + D) + 1;

    @(negedge CLK);
    EN = 1'b1; START = 1'b1; LOG2N = 4'(l); INV = inv;
    @(negedge CLK);
    START = 1'b0;
    ecyc = 1; wall = 1; fresh = 1'b1;
    ri = 0; bi = 0; wi = 0; frz_left = 0; got_done = 1'b0;
    prev = outs_w;

    while (!got_done && wall < 2 * done_cyc + 64) begin
      if (fresh) begin
        exp_rd = (ri < tot) && (exp_q[ri].cyc == ecyc);
        exp_bs = (bi < tot) && (exp_q[bi].cyc + RD_LAT == ecyc);
        exp_wr = (wi < tot) && (exp_q[wi].cyc + D == ecyc);
        chk("rd_en", o_RD_EN, exp_rd);
        chk("but_strob", o_BUT_STROB, exp_bs);
        chk("wr", o_WR, exp_wr);
        chk("done", o_DONE, ecyc == done_cyc);
        chk("busy", o_BUSY, 1);
        chk("err_run", o_ERR, 0);
        chk("conj", o_W_CONJ, inv);
        if (exp_rd) begin
          chk("rd_a", o_RD_A_ADDR, exp_q[ri].a);
          chk("rd_b", o_RD_B_ADDR, exp_q[ri].b);
          chk("w_addr", o_W_ADDR, exp_q[ri].w);
          chk("layer", o_LAYER, exp_q[ri].s);
          chk("first", o_FIRST, exp_q[ri].s == 0);
          ri++;
        end else begin
          chk("first_idle", o_FIRST, 0);
        end
        if (exp_wr) begin
          chk("wr_a", o_WR_A_ADDR, exp_q[wi].a);
          chk("wr_b", o_WR_B_ADDR, exp_q[wi].b);
          wi++;
        end
        if (exp_bs) bi++;
        if (ecyc == done_cyc) got_done = 1'b1;
        if (abort_at != 0 && ecyc == abort_at) begin
          #1 RST = 1'b1;
          #1 chk("abort_zero", outs_w, 0);
          #1 RST = 1'b0;
          START = 1'b0; EN = 1'b1;
          return;
        end
      end else begin
        chk("hold", outs_w, prev);
      end
      prev = outs_w;
      if (!got_done) begin
        if (fresh && ecyc == freeze_at) frz_left = 3;
        if (frz_left > 0) begin
          EN = 1'b0;
          frz_left--;
        end else if (en_rand) begin
          EN = ($urandom_range(0, 7) != 0);
        end else begin
          EN = 1'b1;
        end
        if (noise) begin
          START = ($urandom_range(0, 3) == 0);
          LOG2N = 4'($urandom_range(0, 15));
          INV   = 1'($urandom_range(0, 1));
        end
        en_used = EN;
        @(negedge CLK);
        wall++;
        if (en_used) ecyc++;
        fresh = en_used;
      end
    end

    chk("done_seen", got_done, 1);
    chk("n_rd", ri, tot);
    chk("n_wr", wi, tot);
    if (!got_done) begin
      #1 RST = 1'b1;
      #1 RST = 1'b0;
    end

    // START in the DONE cycle must be ignored.
    EN = 1'b1; START = 1'b1; LOG2N = 4'd3; INV = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    chk("post_busy", o_BUSY, 0);
    chk("post_done", o_DONE, 0);
    chk("post_rd", o_RD_EN, 0);
    @(negedge CLK);
    chk("post_rd2", o_RD_EN, 0);
    chk("post_busy2", o_BUSY, 0);
  endtask

  initial begin
    #1 RST = 1'b1;
    #10 chk("reset_outs", outs_w, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_outs", outs_w, 0);

    err_test(0);
    err_test(6);
    err_test(15);

    run(3, 1'b0, 1'b0, 1'b0, 0, 0);   // reference size: DONE at 28
    run(3, 1'b0, 1'b0, 1'b0, 0, 0);   // back-to-back identical run
    run(1, 1'b0, 1'b0, 1'b0, 0, 0);   // single butterfly
    run(5, 1'b0, 1'b0, 1'b0, 0, 0);   // maximum size: 80 butterflies
    run(3, 1'b1, 1'b1, 1'b0, 0, 0);   // inverse with START noise while busy
    run(3, 1'b0, 1'b0, 1'b0, 11, 0);  // 3-cycle freeze in layer 1
    run(4, 1'b0, 1'b0, 1'b0, 0, 5);   // asynchronous abort in layer 0
    run(2, 1'b0, 1'b0, 1'b0, 0, 0);   // clean run after abort

    for (int r = 0; r < 8; r++) begin
      run($urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
